cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (read-only refill) and the data cache (read refill / write-through).
- Sits between both caches and the memory model.
- Latches one granted request, drives the memory port with registered signals, and steers the memory ready/data back to the granted cache only.
- Supports cancellation by the requester, e.g. the Icache dropping its request on a branch.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- i_req  in  1  Icache read request (Icache r_mem); held until i_ready, or dropped to cancel
- i_addr  in  ADDR_W  Icache read address
- i_ready  out  1  Icache transfer done, one-cycle pulse
- i_rdata  out  DATA_W  read data to Icache, valid with i_ready
- d_req  in  1  Dcache request; held until d_ready, or dropped to cancel
- d_we  in  1  Dcache write (1) / read (0), sampled with d_req
- d_addr  in  ADDR_W  Dcache address
- d_wdata  in  DATA_W  Dcache write data
- d_ready  out  1  Dcache transfer done, one-cycle pulse
- d_rdata  out  DATA_W  read data to Dcache, valid with d_ready
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_ready  in  1  memory done pulse; mem_rdata valid in the same cycle
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, last_grant=I.
  - i_ready, d_ready = 0; i_rdata, d_rdata = 0 (combinational from state).
  - Reset mid-transaction aborts immediately; memory must tolerate mem_req falling without completion.

- States: IDLE, GNT_I, GNT_D, DRAIN.
  - IDLE:
    - d_req → GNT_D; latch d_addr, d_we, d_wdata into the mem_* registers; mem_req=1 from the next cycle.
    - Else i_req → GNT_I; latch i_addr; mem_we=0.
    - Both requests in the same cycle: Dcache wins (fixed priority, unless ARB_RR_EN).
    - Latency: request visible in IDLE → mem_req=1 exactly one cycle later.
  - GNT_X (X is I or D):
    - mem_ready=1 and x_req=1: x_ready=1 and x_rdata=mem_rdata combinationally in that cycle; mem_req←0; → IDLE; last_grant←X.
    - x_req=0 without mem_ready (cancel): mem_req←0; → DRAIN.
    - x_req=0 and mem_ready=1 in the same cycle: completion discarded (x_ready=0); mem_req←0; → IDLE.
  - DRAIN:
    - mem_req=0.
    - Waits for the stale mem_ready pulse, which is discarded, then → IDLE.
    - Also returns to IDLE if no mem_ready arrives within 1 cycle, since memory does not complete unrequested transfers.
    - Requests are not accepted in DRAIN.
- The non-granted requester always sees ready=0 and rdata=0.
- The granted request's address and data are frozen in the mem_* registers; requester changes to addr or wdata while granted are ignored.
- Back-to-back: from completion (IDLE on the next cycle), a pending request is granted immediately, so minimum spacing is 1 idle cycle between mem_req pulses.
- mem_we=1 only in GNT_D with the latched d_we=1.
- Write completion: d_ready pulses and d_rdata is don't-care (driven as mem_rdata).

Optional Feature:
- Macro: ARB_RR_EN.
- Defined: a simultaneous i_req and d_req in IDLE is granted to the requester that is not last_grant (round-robin). last_grant updates only on successful completion; cancels do not update it.
- Undefined: fixed Dcache priority. last_grant is not implemented (or is unused and optimised out).

Decomposition:
- Shared package/header cache_arb_defs holds:
  - state encodings: IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2, DRAIN=2'd3
  - grant IDs: GRANT_I=1'b0, GRANT_D=1'b1
  - default ADDR_W and DATA_W
- One sub-module, arb_pick: combinational 2-way picker. Inputs: i_req, d_req, last_grant. Outputs: grant_valid, grant_id. The round-robin logic lives here under ARB_RR_EN.

Test Plan:
- Single Icache read: i_req=1, i_addr=0x00001000; memory returns 0xDEADBEEF after 3 cycles.
  → mem_req=1 one cycle after i_req, mem_we=0, mem_addr=0x1000; i_ready pulses once with i_rdata=0xDEADBEEF; d_ready stays 0.
- Simultaneous requests in the same cycle: i_req with 0x2000, d_req read with 0x8000.
  → Dcache granted first (mem_addr=0x8000), then Icache (0x2000).
  → With ARB_RR_EN and last_grant=D, Icache is granted first instead.
- Dcache write: d_req=1, d_we=1, d_addr=0x8004, d_wdata=0x12345678.
  → mem_we=1 and mem_wdata=0x12345678 held until mem_ready; d_ready pulses once.
- Icache cancel: i_req dropped 2 cycles after grant; memory asserts mem_ready one cycle later.
  → mem_req falls the cycle after the drop; the stale mem_ready is swallowed in DRAIN; i_ready=0; a following d_req is served correctly.
- Requester changes d_addr from 0x8000 to 0x9000 while granted.
  → mem_addr stays 0x8000 until completion.
- Reset asserted while in GNT_D.
  → mem_req=0, both ready signals 0 immediately; state IDLE after rstn rises.

Source files
------------

// File: rtl/cache_arb_defs.sv
// -----------------------------------------------------------------------------
// cache_arb_defs
// Shared definitions for the cache-to-memory arbiter: FSM state encoding,
// grant identifiers and default bus widths.
// Optional build macro used by importers: ARB_RR_EN (round-robin tie-break).
// -----------------------------------------------------------------------------
package cache_arb_defs;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2,
      DRAIN = 2'd3
   } arb_state_t;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

endpackage

// File: rtl/arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational 2-way picker between the Icache and the Dcache.
// Build macro: ARB_RR_EN
//   undefined : Dcache always wins a tie (last_grant is ignored)
//   defined   : a tie goes to the requester that was not served last
// Ports:
//   i_req, d_req  : raw requests from the two caches
//   last_grant    : requester of the most recent successful transfer
//   grant_valid   : at least one request present
//   grant_id      : chosen requester (GRANT_I / GRANT_D)
// -----------------------------------------------------------------------------
module arb_pick
   import cache_arb_defs::*;
(
   input  logic   i_req,
   input  logic   d_req,
   input  grant_t last_grant,
   output logic   grant_valid,
   output grant_t grant_id
);

`ifdef ARB_RR_EN
   // Pick the requester; a tie alternates away from the last served cache.
   always_comb begin
      grant_valid = i_req | d_req;
      grant_id    = GRANT_I;
      if (i_req && d_req) begin
         grant_id = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
      end else if (d_req) begin
         grant_id = GRANT_D;
      end else begin
         grant_id = GRANT_I;
      end
   end
`else
   logic unused_last_grant_s;

   assign unused_last_grant_s = last_grant;

   // Pick the requester; the Dcache has fixed priority on a tie.
   always_comb begin
      grant_valid = i_req | d_req;
      grant_id    = GRANT_I;
      if (d_req) begin
         grant_id = GRANT_D;
      end else begin
         grant_id = GRANT_I;
      end
   end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cache_mem_arbiter
// Shares one main-memory port between the Icache (read refill) and the Dcache
// (read refill / write-through). One request is latched into registered
// mem_* outputs; memory ready/data are steered only to the granted cache.
// A requester may cancel by dropping its request; the arbiter then spends one
// DRAIN cycle swallowing the stale memory completion.
// Build macro: ARB_RR_EN (round-robin tie-break instead of Dcache priority).
// Ports:
//   clk, rstn                         : clock, async active-low reset
//   i_req/i_addr -> i_ready/i_rdata   : Icache read channel
//   d_req/d_we/d_addr/d_wdata
//                -> d_ready/d_rdata   : Dcache read/write channel
//   mem_req/mem_we/mem_addr/mem_wdata : registered memory request
//   mem_ready/mem_rdata               : memory completion pulse and data
// -----------------------------------------------------------------------------
module cache_mem_arbiter
   import cache_arb_defs::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t state_r;
   grant_t     last_grant_r;
   logic       grant_valid_s;
   grant_t     grant_id_s;

   arb_pick u_arb_pick (
      .i_req       (i_req),
      .d_req       (d_req),
      .last_grant  (last_grant_r),
      .grant_valid (grant_valid_s),
      .grant_id    (grant_id_s)
   );

   // Arbiter FSM and registered memory-port outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r      <= IDLE;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= {ADDR_W{1'b0}};
         mem_wdata    <= {DATA_W{1'b0}};
         last_grant_r <= GRANT_I;
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_valid_s) begin
                  mem_req <= 1'b1;
                  if (grant_id_s == GRANT_D) begin
                     state_r   <= GNT_D;
                     mem_we    <= d_we;
                     mem_addr  <= d_addr;
                     mem_wdata <= d_wdata;
                  end else begin
                     state_r   <= GNT_I;
                     mem_we    <= 1'b0;
                     mem_addr  <= i_addr;
                     mem_wdata <= {DATA_W{1'b0}};
                  end
               end
            end
            GNT_I: begin
               if (!i_req) begin
                  // Cancel: a coincident completion is dropped, else drain it.
                  mem_req <= 1'b0;
                  state_r <= mem_ready ? IDLE : DRAIN;
               end else if (mem_ready) begin
                  mem_req      <= 1'b0;
                  state_r      <= IDLE;
                  last_grant_r <= GRANT_I;
               end
            end
            GNT_D: begin
               if (!d_req) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  state_r <= mem_ready ? IDLE : DRAIN;
               end else if (mem_ready) begin
                  mem_req      <= 1'b0;
                  mem_we       <= 1'b0;
                  state_r      <= IDLE;
                  last_grant_r <= GRANT_D;
               end
            end
            DRAIN: begin
               // Memory answers a cancelled transfer at most one cycle late,
               // so a single cycle here covers both the pulse and its absence.
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
            end
         endcase
      end
   end

   // Steer the memory completion to the granted, still-requesting cache only.
   always_comb begin
      i_ready = 1'b0;
      i_rdata = {DATA_W{1'b0}};
      d_ready = 1'b0;
      d_rdata = {DATA_W{1'b0}};
      case (state_r)
         GNT_I: begin
            if (i_req && mem_ready) begin
               i_ready = 1'b1;
               i_rdata = mem_rdata;
            end else begin
               i_ready = 1'b0;
               i_rdata = {DATA_W{1'b0}};
            end
         end
         GNT_D: begin
            if (d_req && mem_ready) begin
               d_ready = 1'b1;
               d_rdata = mem_rdata;
            end else begin
               d_ready = 1'b0;
               d_rdata = {DATA_W{1'b0}};
            end
         end
         default: begin
            i_ready = 1'b0;
            d_ready = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_mem_arbiter
// Directed bench for cache_mem_arbiter with a small latency-programmable
// memory responder and two scoreboard queues: expected memory requests
// (checked when mem_req rises) and expected cache completions (checked when
// i_ready/d_ready pulse).
// -----------------------------------------------------------------------------
module tb_cache_mem_arbiter;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [31:0] wdata;
   } mem_exp_t;

   typedef struct packed {
      logic        is_d;
      logic        chk_data;
      logic [31:0] data;
   } resp_exp_t;

   logic        clk;
   logic        rstn;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ready;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   int total = 0;
   int bad   = 0;

   mem_exp_t  mem_q[$];
   resp_exp_t resp_q[$];

   int   mem_lat;
   logic mdl_busy;
   int   mdl_cnt;
   logic prev_req;

   cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_ready   (i_ready),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ready   (d_ready),
      .d_rdata   (d_rdata),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return (a == 32'h0000_1000) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_5A5A);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory responder: completes an accepted request mem_lat cycles after
   // mem_req is first seen, even if the request was withdrawn meanwhile.
   always @(posedge clk) begin
      if (!rstn) begin
         mdl_busy  <= 1'b0;
         mdl_cnt   <= 0;
         mem_ready <= 1'b0;
         mem_rdata <= 32'h0000_0000;
      end else if (mem_ready) begin
         mem_ready <= 1'b0;
         mdl_busy  <= 1'b0;
      end else if (mdl_busy) begin
         if (mdl_cnt <= 1) begin
            mem_ready <= 1'b1;
            mem_rdata <= mem_data(mem_addr);
         end else begin
            mdl_cnt <= mdl_cnt - 1;
         end
      end else if (mem_req) begin
         mdl_busy <= 1'b1;
         mdl_cnt  <= mem_lat - 1;
      end
   end

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      mem_exp_t  me;
      resp_exp_t re;
      if (!rstn) begin
         prev_req = 1'b0;
      end else begin
         if (mem_req && !prev_req) begin
            if (mem_q.size() == 0) begin
               chk("unexpected_mem_req", {32'h0, mem_addr}, 64'h0);
            end else begin
               me = mem_q.pop_front();
               chk("mem_addr", mem_addr, me.addr);
               chk("mem_we", mem_we, me.we);
               if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
            end
         end
         prev_req = mem_req;
         if (i_ready || d_ready) begin
            chk("ready_exclusive", i_ready & d_ready, 1'b0);
            if (resp_q.size() == 0) begin
               chk("unexpected_ready", {i_ready, d_ready}, 2'b00);
            end else begin
               re = resp_q.pop_front();
               chk("ready_port_is_d", d_ready, re.is_d);
               if (re.chk_data) chk("rdata", re.is_d ? d_rdata : i_rdata, re.data);
            end
         end
         if (!i_ready) chk("i_rdata_zero", i_rdata, 32'h0);
         if (!d_ready) chk("d_rdata_zero", d_rdata, 32'h0);
      end
   end

   // Wait (bounded) for a completion on one port, optionally checking that the
   // latched request stays frozen, then drop the request the following cycle.
   task automatic wait_done(input logic is_d, input logic hold, input logic [31:0] h_addr,
                            input logic h_we, input logic [31:0] h_wdata);
      int   k;
      logic done;
      k    = 0;
      done = 1'b0;
      while (!done && k < 40) begin
         @(posedge clk); #1;
         k++;
         if (hold && mem_req) begin
            chk("hold_addr", mem_addr, h_addr);
            chk("hold_we", mem_we, h_we);
            if (h_we) chk("hold_wdata", mem_wdata, h_wdata);
         end
         done = is_d ? d_ready : i_ready;
      end
      chk(is_d ? "d_done_timeout" : "i_done_timeout", done, 1'b1);
      @(posedge clk); #1;
      if (is_d) begin
         d_req = 1'b0;
         d_we  = 1'b0;
      end else begin
         i_req = 1'b0;
      end
   endtask

   initial begin
      rstn    = 1'b0;
      i_req   = 1'b0;
      i_addr  = 32'h0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = 32'h0;
      d_wdata = 32'h0;
      mem_lat = 3;
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_i_ready", i_ready, 1'b0);
      chk("rst_d_ready", d_ready, 1'b0);
      chk("rst_i_rdata", i_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;

      // Single Icache read with one-cycle request latency
      mem_q.push_back('{addr: 32'h0000_1000, we: 1'b0, wdata: 32'h0});
      resp_q.push_back('{is_d: 1'b0, chk_data: 1'b1, data: 32'hDEAD_BEEF});
      i_req  = 1'b1;
      i_addr = 32'h0000_1000;
      chk("lat_before", mem_req, 1'b0);
      @(posedge clk); #1;
      chk("lat_one", mem_req, 1'b1);
      chk("lat_we", mem_we, 1'b0);
      wait_done(1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0);

      // Dcache write: we/wdata held until completion
      mem_q.push_back('{addr: 32'h0000_8004, we: 1'b1, wdata: 32'h1234_5678});
      resp_q.push_back('{is_d: 1'b1, chk_data: 1'b0, data: 32'h0});
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h0000_8004;
      d_wdata = 32'h1234_5678;
      wait_done(1'b1, 1'b1, 32'h0000_8004, 1'b1, 32'h1234_5678);

      // Simultaneous requests, last served was the Dcache
`ifdef ARB_RR_EN
      mem_q.push_back('{addr: 32'h0000_2000, we: 1'b0, wdata: 32'h0});
      mem_q.push_back('{addr: 32'h0000_8000, we: 1'b0, wdata: 32'h0});
      resp_q.push_back('{is_d: 1'b0, chk_data: 1'b1, data: mem_data(32'h0000_2000)});
      resp_q.push_back('{is_d: 1'b1, chk_data: 1'b1, data: mem_data(32'h0000_8000)});
`else
      mem_q.push_back('{addr: 32'h0000_8000, we: 1'b0, wdata: 32'h0});
      mem_q.push_back('{addr: 32'h0000_2000, we: 1'b0, wdata: 32'h0});
      resp_q.push_back('{is_d: 1'b1, chk_data: 1'b1, data: mem_data(32'h0000_8000)});
      resp_q.push_back('{is_d: 1'b0, chk_data: 1'b1, data: mem_data(32'h0000_2000)});
`endif
      i_req  = 1'b1;
      i_addr = 32'h0000_2000;
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h0000_8000;
`ifdef ARB_RR_EN
      wait_done(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      wait_done(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
`else
      wait_done(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      wait_done(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
`endif

      // Address change while granted is ignored
      mem_lat = 4;
      mem_q.push_back('{addr: 32'h0000_8000, we: 1'b0, wdata: 32'h0});
      resp_q.push_back('{is_d: 1'b1, chk_data: 1'b1, data: mem_data(32'h0000_8000)});
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h0000_8000;
      @(posedge clk); #1;
      d_addr = 32'h0000_9000;
      wait_done(1'b1, 1'b1, 32'h0000_8000, 1'b0, 32'h0);

      // Icache cancel two cycles after grant, stale completion swallowed
      mem_lat = 3;
      mem_q.push_back('{addr: 32'h0000_3000, we: 1'b0, wdata: 32'h0});
      i_req  = 1'b1;
      i_addr = 32'h0000_3000;
      @(posedge clk); #1;
      chk("cancel_granted", mem_req, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      i_req = 1'b0;
      @(posedge clk); #1;
      chk("cancel_req_fall", mem_req, 1'b0);
      chk("cancel_stale_seen", mem_ready, 1'b1);
      chk("cancel_i_ready", i_ready, 1'b0);
      mem_q.push_back('{addr: 32'h0000_A000, we: 1'b0, wdata: 32'h0});
      resp_q.push_back('{is_d: 1'b1, chk_data: 1'b1, data: mem_data(32'h0000_A000)});
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h0000_A000;
      wait_done(1'b1, 1'b1, 32'h0000_A000, 1'b0, 32'h0);

      // Reset while in GNT_D aborts immediately
      mem_lat = 8;
      mem_q.push_back('{addr: 32'h0000_C000, we: 1'b0, wdata: 32'h0});
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h0000_C000;
      @(posedge clk); #1;
      chk("rst_mid_granted", mem_req, 1'b1);
      @(posedge clk); #1;
      rstn = 1'b0;
      #1;
      chk("rst_mid_mem_req", mem_req, 1'b0);
      chk("rst_mid_d_ready", d_ready, 1'b0);
      chk("rst_mid_i_ready", i_ready, 1'b0);
      chk("rst_mid_mem_addr", mem_addr, 32'h0);
      d_req = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;

      // Fresh Icache read after reset: arbiter back in IDLE
      mem_lat = 3;
      mem_q.push_back('{addr: 32'h0000_4000, we: 1'b0, wdata: 32'h0});
      resp_q.push_back('{is_d: 1'b0, chk_data: 1'b1, data: mem_data(32'h0000_4000)});
      i_req  = 1'b1;
      i_addr = 32'h0000_4000;
      @(posedge clk); #1;
      chk("post_rst_grant", mem_req, 1'b1);
      wait_done(1'b0, 1'b1, 32'h0000_4000, 1'b0, 32'h0);

      repeat (5) @(posedge clk);
      #1;
      chk("mem_q_drained", mem_q.size(), 0);
      chk("resp_q_drained", resp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
